// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe game controller: cell codes,
// FSM state encoding, winner codes and the table of the eight winning lines.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef cell_t [8:0] board_t;

    typedef logic [1:0] state_t;
    localparam state_t PLAY  = 2'd0;
    localparam state_t CHECK = 2'd1;
    localparam state_t OVER  = 2'd2;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    // Rows, columns, then the two diagonals, as row-major cell indices.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic line_win(input board_t b, input cell_t code);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (b[WIN_LINES[l][0]] == code &&
                b[WIN_LINES[l][1]] == code &&
                b[WIN_LINES[l][2]] == code) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic board_full(input board_t b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (b[i] == EMPTY) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

endpackage

// File: rtl/game_controller_if.sv
// Button inputs and board/status outputs exchanged between the game controller
// and the board-level logic (buttons in, video_controller feed out).
interface game_controller_if;

    logic       btn_move;
    logic       btn_place;
    logic [1:0] block00;
    logic [1:0] block01;
    logic [1:0] block02;
    logic [1:0] block10;
    logic [1:0] block11;
    logic [1:0] block12;
    logic [1:0] block20;
    logic [1:0] block21;
    logic [1:0] block22;
    logic [3:0] selected;
    logic       turn;
    logic [1:0] winner;
    logic       game_over;

    // Board side: drives the raw buttons and consumes the rendered state.
    modport master (
        output btn_move, btn_place,
        input  block00, block01, block02, block10, block11, block12,
        input  block20, block21, block22,
        input  selected, turn, winner, game_over
    );

    // Controller side.
    modport slave (
        input  btn_move, btn_place,
        output block00, block01, block02, block10, block11, block12,
        output block20, block21, block22,
        output selected, turn, winner, game_over
    );

endinterface

// File: rtl/button_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-flop synchronizer, stability
// debouncer and rising-edge detector.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             vld1_q;
    logic             vld2_q;
    logic             armed_q;
    logic             armed_d;
    logic             stable_q;
    logic             stable_d;
    logic             prev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A button still held from before reset must be seen released (once the
    // synchronizer holds real samples again) before its edges count.
    assign armed_d = armed_q | (vld2_q & ~sync2_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            vld1_q   <= 1'b0;
            vld2_q   <= 1'b0;
            armed_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            vld1_q   <= 1'b1;
            vld2_q   <= vld1_q;
            armed_q  <= armed_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            pulse_q  <= stable_q & ~prev_q & armed_q;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Tic-tac-toe board and turn engine: cursor movement, alternating mark
// placement, win/draw detection and restart, feeding video_controller.
module game_controller
    import tictactoe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    game_controller_if.slave  bus
);

    logic       mv_p;
    logic       pl_p;

    state_t     state_q;
    state_t     state_d;
    board_t     board_q;
    board_t     board_d;
    logic [3:0] sel_q;
    logic [3:0] sel_d;
    logic       turn_q;
    logic       turn_d;
    logic [1:0] winner_q;
    logic [1:0] winner_d;
    logic       over_q;
    logic       over_d;
    cell_t      mover;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_move (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .btn_i   (bus.btn_move),
        .pulse_o (mv_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_place (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .btn_i   (bus.btn_place),
        .pulse_o (pl_p)
    );

    // Player 1 marks 01, player 2 marks 10.
    assign mover = cell_t'({turn_q, ~turn_q});

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        sel_d    = sel_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        over_d   = over_q;
        case (state_q)
            PLAY: begin
                // Place has priority; a simultaneous move press is dropped.
                if (pl_p) begin
                    if (board_q[sel_q] == EMPTY) begin
                        board_d[sel_q] = mover;
                        state_d        = CHECK;
                    end
                end else if (mv_p) begin
                    sel_d = (sel_q == 4'd8) ? 4'd0 : sel_q + 4'd1;
                end
            end
            CHECK: begin
                if (line_win(board_q, mover)) begin
                    winner_d = mover;
                    over_d   = 1'b1;
                    state_d  = OVER;
                end else if (board_full(board_q)) begin
                    winner_d = W_DRAW;
                    over_d   = 1'b1;
                    state_d  = OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (pl_p) begin
                    for (int i = 0; i < 9; i++) begin
                        board_d[i] = EMPTY;
                    end
                    sel_d    = 4'd0;
                    turn_d   = 1'b0;
                    winner_d = W_NONE;
                    over_d   = 1'b0;
                    state_d  = PLAY;
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= PLAY;
            for (int i = 0; i < 9; i++) begin
                board_q[i] <= EMPTY;
            end
            sel_q    <= 4'd0;
            turn_q   <= 1'b0;
            winner_q <= W_NONE;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            sel_q    <= sel_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            over_q   <= over_d;
        end
    end

    assign bus.block00   = board_q[0];
    assign bus.block01   = board_q[1];
    assign bus.block02   = board_q[2];
    assign bus.block10   = board_q[3];
    assign bus.block11   = board_q[4];
    assign bus.block12   = board_q[5];
    assign bus.block20   = board_q[6];
    assign bus.block21   = board_q[7];
    assign bus.block22   = board_q[8];
    assign bus.selected  = sel_q;
    assign bus.turn      = turn_q;
    assign bus.winner    = winner_q;
    assign bus.game_over = over_q;

endmodule

// File: doc/game_controller.md
# game_controller

Board-state and turn engine feeding `video_controller`. Conditions two raw push-button inputs, moves a cursor over the 3×3 grid, places alternating player marks, and detects win or draw. Drives the nine 2-bit cell codes and the 4-bit `selected` index that `video_controller` renders, replacing the constant assigns at the top level.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz); bench overrides to 4.
- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_move`  in  1  raw, asynchronous button level, 1 = pressed: advance cursor.
- `btn_place`  in  1  raw, asynchronous button level, 1 = pressed: place mark, or restart when the game is over.
- `block00` … `block22`  out  2 each  cell code, row-major (`blockRC`): 00 empty, 01 player 1, 10 player 2; 11 never driven.
- `selected`  out  4  cursor index 0..8 = row*3+col.
- `turn`  out  1  0 = player 1 to move, 1 = player 2.
- `winner`  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
- `game_over`  out  1  high while in OVER.

## Operation
- Each button: 2-flop synchronizer -> debouncer -> rising-edge detector -> 1-cycle pulse (`mv_p`, `pl_p`).
- Debouncer: counter clears while sync level == stable level; otherwise increments; when count reaches DEBOUNCE_CYCLES-1 and the level still differs, stable level takes the sync level and the counter clears. Glitches shorter than DEBOUNCE_CYCLES are rejected.
- FSM states: PLAY, CHECK, OVER.
- PLAY, `pl_p`: if cell[selected] == 00, write {turn, ~turn} (01 for p1, 10 for p2) and go to CHECK; if occupied, ignore and stay in PLAY.
- PLAY, `mv_p` without `pl_p`: selected = (selected == 8) ? 0 : selected+1. If both pulses occur in the same cycle, place wins, move is dropped, and place uses the pre-move index.
- CHECK (exactly 1 cycle): test all 8 lines (3 rows, 3 cols, 2 diagonals) for the mover's code.
  - Any line matches: winner = mover code; go to OVER.
  - No line matches and all 9 cells are non-zero: winner = 11; go to OVER.
  - Otherwise: toggle turn; go to PLAY.
  - Pulses arriving during CHECK are dropped.
- OVER: board, turn and selected frozen; `mv_p` is ignored. `pl_p` clears all cells to 00 and sets selected = 0, turn = 0, winner = 00; go to PLAY.
- Reset: all cells 00, selected 0, turn 0, winner 00, game_over 0, state PLAY; synchronizer, stable levels and edge registers 0; counters 0. Reset mid-press: the held button produces no pulse until it is released and pressed again.

## Timing
- Raw edge to pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle (±1 cycle synchronizer uncertainty).
- Pulse in cycle n:
  - Cell or `selected` register updates at the end of n.
  - CHECK occupies n+1.
  - `turn`, `winner` and `game_over` are updated at the end of n+1 and visible in n+2.
- All outputs are registered; nothing is combinational from the button inputs.
- `selected` never leaves 0..8 and wraps 8 -> 0.
- The next accepted place can occur no earlier than n+2.

## Structure
- Package `tictactoe_pkg`:
  - `cell_t` (EMPTY=2'b00, P1=2'b01, P2=2'b10).
  - `state_t` (PLAY, CHECK, OVER).
  - Winner codes (W_NONE, W_P1, W_P2, W_DRAW).
  - `WIN_LINES`: 8×3 constant array of cell indices.
- Board is held internally as a `cell_t [8:0]` array; the `blockRC` ports are assigned from it.
- Sub-module `button_conditioner` (synchronizer, debouncer, edge pulse; parameter DEBOUNCE_CYCLES), instantiated twice.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, then hold `btn_move` for 20 cycles -> exactly one pulse; selected 0 -> 1; all blocks 00; turn 0.
- `btn_move` glitch high for 2 cycles -> no pulse; selected unchanged.
- Nine move presses from selected 0 -> selected visits 1..8 then wraps to 0.
- Place at 0, then place at 0 again on p2's turn -> block00 = 01; second place ignored; turn stays 1; block00 still 01.
- Sequence p1@0, p2@3, p1@1, p2@4, p1@2:
  - block00, block01, block02 = 01.
  - Two cycles after the last pulse: winner = 01, game_over = 1.
  - A further move press leaves selected unchanged.
  - A place press clears the board, selected = 0, turn = 0, winner = 00.
- Draw fill p1@0, p2@1, p1@2, p2@4, p1@3, p2@5, p1@7, p2@6, p1@8 -> winner = 11, game_over = 1.
- Simultaneous pulses -> place applied at the old index; selected unchanged.
- Reset asserted mid-game -> all outputs at reset values on the next cycle.
